// File: rtl/evt_sched_pkg.sv
// Shared types and helpers for the evt_sched event/delay process scheduler.
package evt_sched_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_EVT = 2'd1,
        WAIT_DLY = 2'd2
    } proc_state_e;

    function automatic int evt_w(input int nevt);
        return (nevt <= 1) ? 1 : $clog2(nevt);
    endfunction

endpackage

// File: rtl/evt_sched_proc.sv
// One process slot: RUN / WAIT_EVT / WAIT_DLY FSM with latched event id and delay counter.
module evt_sched_proc
    import evt_sched_pkg::*;
#(
    parameter int NEVT  = 4,
    parameter int EVT_W = 2,
    parameter int DLY_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wait_vld,
    input  logic [EVT_W-1:0] wait_evt,
    input  logic             dly_vld,
    input  logic [DLY_W-1:0] dly_val,
    input  logic [NEVT-1:0]  fire,
    output proc_state_e      state,
    output logic             wake,
    output logic             blocked
);

    proc_state_e      state_q, state_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic             wake_q, wake_d;
    logic             blocked_q, blocked_d;
    logic             hit_s, short_dly_s, dly_done_s;

    // Ids outside 0..NEVT-1 never match, so such a wait blocks until reset.
    always_comb begin
        hit_s = 1'b0;
        for (int e = 0; e < NEVT; e++) begin
            hit_s = hit_s | (fire[e] & (evt_q == EVT_W'(e)));
        end
    end

    assign short_dly_s = (dly_val <= DLY_W'(1));
    assign dly_done_s  = (cnt_q <= DLY_W'(1));

    // Next-state logic; delays of 0 or 1 wake next cycle without visibly blocking.
    always_comb begin
        state_d = state_q;
        evt_d   = evt_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (wait_vld) begin
                    state_d = WAIT_EVT;
                    evt_d   = wait_evt;
                end else if (dly_vld && !short_dly_s) begin
                    state_d = WAIT_DLY;
                    cnt_d   = dly_val - DLY_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_EVT: begin
                if (hit_s) begin
                    state_d = RUN;
                    evt_d   = '0;
                end else begin
                    state_d = WAIT_EVT;
                end
            end
            WAIT_DLY: begin
                if (dly_done_s) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - DLY_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                evt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: wake pulses in the cycle the slot returns to RUN.
    always_comb begin
        wake_d    = 1'b0;
        blocked_d = (state_d != RUN);
        case (state_q)
            RUN:      wake_d = ~wait_vld & dly_vld & short_dly_s;
            WAIT_EVT: wake_d = hit_s;
            WAIT_DLY: wake_d = dly_done_s;
            default:  wake_d = 1'b0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            evt_q     <= '0;
            cnt_q     <= '0;
            wake_q    <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            evt_q     <= evt_d;
            cnt_q     <= cnt_d;
            wake_q    <= wake_d;
            blocked_q <= blocked_d;
        end
    end

    assign state   = state_q;
    assign wake    = wake_q;
    assign blocked = blocked_q;

endmodule

// File: rtl/evt_sched.sv
// Event scheduler top: NPROC slots, trigger decode, optional deadlock detect.
// Define EVT_SCHED_DEADLOCK_EN to build deadlock detection; otherwise deadlock is 0.
module evt_sched
    import evt_sched_pkg::*;
#(
    parameter int NPROC = 3,
    parameter int NEVT  = 4,
    parameter int DLY_W = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NPROC-1:0]              wait_vld,
    input  logic [NPROC*evt_w(NEVT)-1:0]  wait_evt,
    input  logic [NPROC-1:0]              dly_vld,
    input  logic [NPROC*DLY_W-1:0]        dly_val,
    input  logic [NPROC-1:0]              trig_vld,
    input  logic [NPROC*evt_w(NEVT)-1:0]  trig_evt,
    output logic [NPROC-1:0]              wake,
    output logic [NPROC-1:0]              blocked,
    output logic [NEVT-1:0]               evt_fired,
    output logic                          deadlock
);

    localparam int EVT_W = evt_w(NEVT);

    proc_state_e      state_s [NPROC];
    logic [NPROC-1:0] run_s;
    logic [NEVT-1:0]  evt_fired_d, evt_fired_q;

    // Only RUN slots may fire; out-of-range ids drop out of the decode.
    always_comb begin
        run_s       = '0;
        evt_fired_d = '0;
        for (int p = 0; p < NPROC; p++) begin
            run_s[p] = (state_s[p] == RUN);
            for (int e = 0; e < NEVT; e++) begin
                evt_fired_d[e] = evt_fired_d[e] |
                    (trig_vld[p] & run_s[p] & (trig_evt[p*EVT_W +: EVT_W] == EVT_W'(e)));
            end
        end
    end

    for (genvar g = 0; g < NPROC; g++) begin : g_proc
        evt_sched_proc #(
            .NEVT  (NEVT),
            .EVT_W (EVT_W),
            .DLY_W (DLY_W)
        ) u_proc (
            .clk      (clk),
            .rst_n    (rst_n),
            .wait_vld (wait_vld[g]),
            .wait_evt (wait_evt[g*EVT_W +: EVT_W]),
            .dly_vld  (dly_vld[g]),
            .dly_val  (dly_val[g*DLY_W +: DLY_W]),
            .fire     (evt_fired_d),
            .state    (state_s[g]),
            .wake     (wake[g]),
            .blocked  (blocked[g])
        );
    end

    // Event-fired pulses, one cycle after the honoured triggers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_fired_q <= '0;
        end else begin
            evt_fired_q <= evt_fired_d;
        end
    end

    assign evt_fired = evt_fired_q;

`ifdef EVT_SCHED_DEADLOCK_EN
    logic deadlock_d, deadlock_q;

    // Deadlock when every slot is parked on an event.
    always_comb begin
        deadlock_d = 1'b1;
        for (int p = 0; p < NPROC; p++) begin
            deadlock_d = deadlock_d & (state_s[p] == WAIT_EVT);
        end
    end

    // Deadlock flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deadlock_q <= 1'b0;
        end else begin
            deadlock_q <= deadlock_d;
        end
    end

    assign deadlock = deadlock_q;
`else
    assign deadlock = 1'b0;
`endif

endmodule

// File: doc/evt_sched.md
EVT_SCHED -- requirements
Module: evt_sched

Interface
REQ-001 SHALL have parameter NPROC, default 3, number of process slots.
REQ-002 SHALL have parameter NEVT, default 4, number of named events; EVT_W = max(1, clog2(NEVT)).
REQ-003 SHALL have parameter DLY_W, default 24, delay-count width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wait_vld  in  NPROC  slot i requests to block on an event.
REQ-007 wait_evt  in  NPROC*EVT_W  event id per slot, slice i.
REQ-008 dly_vld  in  NPROC  slot i requests a timed delay.
REQ-009 dly_val  in  NPROC*DLY_W  delay in cycles per slot.
REQ-010 trig_vld  in  NPROC  slot i fires an event.
REQ-011 trig_evt  in  NPROC*EVT_W  fired event id per slot.
REQ-012 wake  out  NPROC  one-cycle pulse: slot i resumes.
REQ-013 blocked  out  NPROC  level: slot i is in WAIT_EVT or WAIT_DLY.
REQ-014 evt_fired  out  NEVT  one-cycle pulse per event triggered.
REQ-015 deadlock  out  1  level: every slot in WAIT_EVT.

Function
REQ-016 Each slot SHALL run an FSM with states RUN, WAIT_EVT and WAIT_DLY.
REQ-017 In RUN, wait_vld SHALL latch wait_evt and enter WAIT_EVT next cycle; wait_vld SHALL take priority over a simultaneous dly_vld, which is then discarded.
REQ-018 In RUN, dly_vld with value D at cycle t SHALL enter WAIT_DLY and pulse wake at cycle t+max(D,1), returning to RUN in that same cycle.
REQ-019 Only slots in RUN SHALL have their trig_vld honoured; wait/dly/trig inputs from blocked slots SHALL be ignored.
REQ-020 An honoured trigger of event e at cycle t SHALL pulse evt_fired[e] at t+1, whether or not any slot waits on e.
REQ-021 A slot in WAIT_EVT on e at cycle t (registered before t) SHALL pulse wake at t+1 and return to RUN when e is triggered at t; triggers are not sticky and no wake SHALL occur for a trigger in the cycle the wait is registered.
REQ-022 Several triggers in one cycle (same or different ids) SHALL all take effect; all matching waiters SHALL wake together.
REQ-023 A RUN slot SHALL be able to trigger and register a wait in the same cycle; its own trigger SHALL NOT wake it.
REQ-024 Trigger ids >= NEVT SHALL be ignored; wait ids >= NEVT SHALL block until reset.
REQ-025 blocked SHALL be registered and track FSM state with no extra latency.
REQ-026 deadlock SHALL be registered, asserted the cycle after all slots are in WAIT_EVT, and deasserted the cycle after any slot leaves.

Reset
REQ-027 rst_n low SHALL immediately force all slots to RUN, clear counters and latched ids, and drive wake, blocked, evt_fired and deadlock to 0.
REQ-028 Reset mid-wait or mid-delay SHALL discard the pending wake; no wake SHALL pulse in the first cycle after release.

Configuration
REQ-029 With EVT_SCHED_DEADLOCK_EN defined, deadlock SHALL behave per REQ-026.
REQ-030 Without EVT_SCHED_DEADLOCK_EN, deadlock SHALL be tied to 0 and no detection logic SHALL be built.

Structure
REQ-031 Package evt_sched_pkg SHALL hold the proc_state_e enum (RUN, WAIT_EVT, WAIT_DLY) and the EVT_W width helper.
REQ-032 Sub-module evt_sched_proc SHALL hold one slot's FSM, latched id and delay counter; evt_sched SHALL instantiate it NPROC times, decode triggers and combine slots for deadlock detection.

Verification
REQ-033 Ring: slot0 dly 1000, then trig 1 and wait 0; slot1 waits 1, triggers 2, waits 1, triggers 0; slot2 waits 2, triggers 1, then waits 2 -> wake order 0,1,2,1,0; each wake one cycle after its trigger; slot2 left blocked.
REQ-034 Slot1 triggers 3 while slot0 and slot2 both wait on 3 -> wake=3'b101 next cycle; evt_fired[3] pulses once.
REQ-035 Trigger event 2 with no waiter, then slot0 waits 2 -> evt_fired[2] pulses; slot0 stays blocked, no wake.
REQ-036 dly_val 0 and dly_val 1 on two slots in the same cycle -> both wake exactly one cycle later.
REQ-037 All three slots wait on 0 -> deadlock=1 next cycle with the macro, 0 without; rst_n pulse -> deadlock=0, blocked=0.
REQ-038 rst_n asserted while slot0 is 5 cycles into a 10-cycle delay -> no wake ever follows; slot0 in RUN after release.
